// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-memory responder.
//   state_t       : responder FSM states (IDLE / WAIT / RESP)
//   DEFAULT_WIDTH : default data / byte-address width
//   DEFAULT_DEPTH : default number of words in the array
//   is_misaligned : true when a byte address is not word aligned
package cpu_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_DEPTH = 32;

   function automatic logic is_misaligned(input logic [1:0] low_bits);
      return low_bits != 2'b00;
   endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port synchronous RAM, DEPTH x WIDTH, registered read.
//   clk   : rising-edge clock
//   en    : access enable (read or write this edge)
//   we    : 1 = write wdata to addr, 0 = read addr into rdata
//   addr  : word index
//   wdata : write data
//   rdata : read data, updated only on enabled reads, otherwise held
// Contents and the read register are deliberately not reset.
module mem_word_array #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 32,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[addr] <= wdata;
         else    rdata     <= mem[addr];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data-memory port. Accepts one load/store
// at a time, waits WAIT_CYCLES cycles, then commits to the word array and
// presents the response until the initiator takes it.
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   req_valid  : request present         req_ready  : responder idle
//   req_write  : 1 = store, 0 = load     req_addr   : byte address
//   req_wdata  : store data
//   resp_valid : response present        resp_ready : initiator accepts
//   resp_rdata : load data (0 for stores and errors)
//   resp_err   : misaligned or out-of-range access
//   busy       : transaction in flight
module data_mem_responder
   import cpu_mem_pkg::*;
#(
   parameter int WIDTH       = DEFAULT_WIDTH,
   parameter int DEPTH       = DEFAULT_DEPTH,
   parameter int WAIT_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [WIDTH-1:0] req_addr,
   input  logic [WIDTH-1:0] req_wdata,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_rdata,
   output logic             resp_err,
   output logic             busy
);

   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_t                state, state_nxt;
   logic [3:0]            cnt;
   logic                  cap_write, cap_err;
   logic [ADDR_WIDTH-1:0] cap_index;
   logic [WIDTH-1:0]      cap_wdata;
   logic                  commit;
   logic                  req_err;
   logic [WIDTH-1:0]      ram_q;

   // Shifting instead of slicing keeps the range check legal for any WIDTH.
   assign req_err = is_misaligned(req_addr[1:0]) |
                    ((req_addr >> (ADDR_WIDTH + 2)) != '0);

   // With zero wait states the commit happens on the accepting edge itself,
   // so the array must see the live request rather than the captured copy.
   logic                  src_write, src_err;
   logic [ADDR_WIDTH-1:0] src_index;
   logic [WIDTH-1:0]      src_wdata;

   assign src_write = (state == IDLE) ? req_write                  : cap_write;
   assign src_err   = (state == IDLE) ? req_err                    : cap_err;
   assign src_index = (state == IDLE) ? req_addr[ADDR_WIDTH+1:2]   : cap_index;
   assign src_wdata = (state == IDLE) ? req_wdata                  : cap_wdata;

   always_comb begin
      state_nxt = state;
      commit    = 1'b0;
      unique case (state)
         IDLE: if (req_valid) begin
            state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
            commit    = (WAIT_CYCLES == 0);
         end
         WAIT: if (cnt == '0) begin
            state_nxt = RESP;
            commit    = 1'b1;
         end
         RESP: if (resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         cap_write <= 1'b0;
         cap_err   <= 1'b0;
         cap_index <= '0;
         cap_wdata <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && req_valid) begin
            cap_write <= req_write;
            cap_err   <= req_err;
            cap_index <= req_addr[ADDR_WIDTH+1:2];
            cap_wdata <= req_wdata;
            cnt       <= CNT_INIT;
         end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   mem_word_array #(
      .WIDTH      (WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_array (
      .clk   (clk),
      .en    (commit & ~src_err),
      .we    (src_write),
      .addr  (src_index),
      .wdata (src_wdata),
      .rdata (ram_q)
   );

   // The read register only updates on a commit, so gating it by state keeps
   // the response stable through a stall and zero everywhere else.
   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);
   assign busy       = (state != IDLE);
   assign resp_err   = (state == RESP) & cap_err;
   assign resp_rdata = (state == RESP && !cap_write && !cap_err) ? ram_q : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

   logic        clk, rst;
   logic        a_req_valid, a_req_ready, a_req_write, a_resp_valid, a_resp_ready, a_resp_err, a_busy;
   logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
   logic        b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready, b_resp_err, b_busy;
   logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;

   int errors = 0;
   int checks = 0;

   data_mem_responder #(.WIDTH(32), .DEPTH(32), .WAIT_CYCLES(2)) dut_a (
      .clk(clk), .rst(rst),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
      .req_addr(a_req_addr), .req_wdata(a_req_wdata),
      .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
      .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .busy(a_busy)
   );

   data_mem_responder #(.WIDTH(32), .DEPTH(32), .WAIT_CYCLES(0)) dut_b (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
      .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .busy(b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one transaction (called at posedge+1, DUT idle). lat counts the
   // accepting cycle as 1 up to the first cycle with resp_valid high.
   task automatic txn(input bit sel, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, output int lat,
                      output logic [31:0] rdata, output logic err);
      if (sel) begin
         b_req_valid = 1'b1; b_req_write = wr; b_req_addr = addr; b_req_wdata = wdata; b_resp_ready = 1'b1;
      end else begin
         a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_wdata = wdata; a_resp_ready = 1'b1;
      end
      @(posedge clk); #1;
      // Request fields are don't-care after acceptance: scramble them.
      if (sel) begin
         b_req_valid = 1'b0; b_req_write = ~wr; b_req_addr = 32'hFFFF_FFFF; b_req_wdata = 32'h5555_5555;
      end else begin
         a_req_valid = 1'b0; a_req_write = ~wr; a_req_addr = 32'hFFFF_FFFF; a_req_wdata = 32'h5555_5555;
      end
      lat = 1;
      while (!(sel ? b_resp_valid : a_resp_valid) && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      rdata = sel ? b_resp_rdata : a_resp_rdata;
      err   = sel ? b_resp_err   : a_resp_err;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      a_req_valid = 1'b1; b_req_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b want 1", a_req_ready); end
      checks++; if (a_resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b want 0", a_resp_valid); end
      checks++; if (a_resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata: got %h want 0", a_resp_rdata); end
      checks++; if (a_resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err: got %b want 0", a_resp_err); end
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", a_busy); end
      checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL rst_busy_b: got %b want 0", b_busy); end
      a_req_valid = 1'b0; b_req_valid = 1'b0;
      #2 rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_no_accept: busy got %b want 0", a_busy); end
   endtask

   task automatic test_store_load;
      int lat; logic [31:0] rd; logic er;
      txn(0, 1'b1, 32'h04, 32'hA5A5_A5A5, lat, rd, er);
      txn(0, 1'b1, 32'h00, 32'h1111_1111, lat, rd, er);
      txn(0, 1'b1, 32'h08, 32'hDEAD_BEEF, lat, rd, er);
      checks++; if (lat !== 3) begin errors++; $display("FAIL store_latency: got %0d want 3", lat); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL store_rdata: got %h want 0", rd); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL store_err: got %b want 0", er); end
      txn(0, 1'b0, 32'h08, 32'h0, lat, rd, er);
      checks++; if (lat !== 3) begin errors++; $display("FAIL load_latency: got %0d want 3", lat); end
      checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata: got %h want deadbeef", rd); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL load_err: got %b want 0", er); end
      txn(0, 1'b0, 32'h04, 32'h0, lat, rd, er);
      checks++; if (rd !== 32'hA5A5_A5A5) begin errors++; $display("FAIL load_04: got %h want a5a5a5a5", rd); end
   endtask

   task automatic test_errors;
      int lat; logic [31:0] rd; logic er;
      txn(0, 1'b0, 32'h0A, 32'h0, lat, rd, er);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b want 1", er); end
      checks++; if (rd !== 32'h0) begin errors++; $display("FAIL misalign_rdata: got %h want 0", rd); end
      txn(0, 1'b1, 32'h80, 32'h1, lat, rd, er);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL range_err: got %b want 1", er); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL range_latency: got %0d want 3", lat); end
      txn(0, 1'b1, 32'h8000_0000, 32'h2, lat, rd, er);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL msb_err: got %b want 1", er); end
      txn(0, 1'b0, 32'h00, 32'h0, lat, rd, er);
      checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL no_alias: got %h want 11111111", rd); end
      checks++; if (er !== 1'b0) begin errors++; $display("FAIL no_alias_err: got %b want 0", er); end
   endtask

   task automatic test_stall;
      int n;
      a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h08; a_resp_ready = 1'b0;
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      n = 0;
      while (!a_resp_valid && n < 40) begin @(posedge clk); #1; n++; end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++; if (a_resp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, a_resp_valid); end
         checks++; if (a_resp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_rdata[%0d]: got %h want deadbeef", i, a_resp_rdata); end
         checks++; if (a_resp_err !== 1'b0) begin errors++; $display("FAIL stall_err[%0d]: got %b want 0", i, a_resp_err); end
         checks++; if (a_req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready[%0d]: got %b want 0", i, a_req_ready); end
         checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL stall_busy[%0d]: got %b want 1", i, a_busy); end
      end
      a_resp_ready = 1'b1;
      @(posedge clk); #1;
      checks++; if (a_busy !== 1'b0 || a_resp_valid !== 1'b0) begin errors++; $display("FAIL stall_release: busy/valid got %b%b want 00", a_busy, a_resp_valid); end
   endtask

   task automatic test_back_to_back;
      int acc [3];
      int n, cyc;
      n = 0; cyc = 0;
      a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h08; a_resp_ready = 1'b1;
      while (n < 3 && cyc < 40) begin
         if (a_req_valid && a_req_ready) begin acc[n] = cyc; n++; end
         @(posedge clk); #1;
         cyc++;
      end
      a_req_valid = 1'b0;
      cyc = 0;
      while (!a_resp_valid && cyc < 40) begin @(posedge clk); #1; cyc++; end
      @(posedge clk); #1;
      checks++; if (n !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", n); end
      else begin
         checks++; if (acc[1] - acc[0] !== 4) begin errors++; $display("FAIL b2b_gap0: got %0d want 4", acc[1] - acc[0]); end
         checks++; if (acc[2] - acc[1] !== 4) begin errors++; $display("FAIL b2b_gap1: got %0d want 4", acc[2] - acc[1]); end
      end
   endtask

   task automatic test_reset_in_wait;
      int lat; logic [31:0] rd; logic er;
      a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h04; a_req_wdata = 32'h1234_5678;
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL rwait_busy: got %b want 1", a_busy); end
      #2 rst = 1'b0;
      #1;
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rwait_async_busy: got %b want 0", a_busy); end
      checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL rwait_async_ready: got %b want 1", a_req_ready); end
      checks++; if (a_resp_valid !== 1'b0) begin errors++; $display("FAIL rwait_async_valid: got %b want 0", a_resp_valid); end
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk); #1;
      txn(0, 1'b0, 32'h04, 32'h0, lat, rd, er);
      checks++; if (rd !== 32'hA5A5_A5A5) begin errors++; $display("FAIL rwait_no_commit: got %h want a5a5a5a5", rd); end
   endtask

   task automatic test_zero_wait;
      int lat; logic [31:0] rd; logic er;
      txn(1, 1'b1, 32'h10, 32'hCAFE_F00D, lat, rd, er);
      checks++; if (lat !== 1) begin errors++; $display("FAIL zw_store_latency: got %0d want 1", lat); end
      txn(1, 1'b0, 32'h10, 32'h0, lat, rd, er);
      checks++; if (lat !== 1) begin errors++; $display("FAIL zw_load_latency: got %0d want 1", lat); end
      checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL zw_load_rdata: got %h want cafef00d", rd); end
      txn(1, 1'b0, 32'h02, 32'h0, lat, rd, er);
      checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL zw_misalign: err/rdata got %b/%h want 1/0", er, rd); end
   endtask

   initial begin
      rst = 1'b0;
      a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_resp_ready = 1'b1;
      b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_resp_ready = 1'b1;
      test_reset();
      test_store_load();
      test_errors();
      test_stall();
      test_back_to_back();
      test_reset_in_wait();
      test_zero_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
